// File: rtl/ping_pong_buffer.sv
// Two-bank ping-pong buffer: the producer fills one bank while the consumer reads the other.
// A commit/release handshake swaps the banks. Optional macro PING_PONG_OVERRUN_COUNT_EN enables a saturating overrun counter.
module ping_pong_buffer #(
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     writeEnable,
    input  logic [ADDRESS_WIDTH-1:0] writeAddress,
    input  logic [DATA_WIDTH-1:0]    writeData,
    input  logic                     writeCommit,
    input  logic                     readEnable,
    input  logic [ADDRESS_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0]    readData,
    output logic                     readValid,
    output logic                     bankReady,
    output logic [ADDRESS_WIDTH:0]   readLength,
    input  logic                     readRelease,
    output logic                     overrun,
    output logic [15:0]              overrunCount
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] MAX_COUNT = (ADDRESS_WIDTH+1)'(DEPTH);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t                   r_state, w_stateNext;
    logic                     r_writeBank;
    logic [ADDRESS_WIDTH:0]   r_writeCount;
    logic [ADDRESS_WIDTH:0]   w_countNext;
    logic [ADDRESS_WIDTH:0]   r_readLength;
    logic [DATA_WIDTH-1:0]    r_readData;
    logic                     r_readValid;
    logic                     r_overrun;
    logic                     w_swap;
    logic                     w_overrun;
    logic [DATA_WIDTH-1:0]    r_mem [0:2*DEPTH-1];

    // Count including this cycle's write, so a write in the commit cycle is part of the frame.
    assign w_countNext = (writeEnable && r_writeCount != MAX_COUNT) ? r_writeCount + 1'b1 : r_writeCount;

    always_comb begin
        w_stateNext = r_state;
        w_swap      = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (writeCommit) begin
                    w_swap      = 1'b1;
                    w_stateNext = S_FULL;
                end
            end
            S_FULL: begin
                if (writeCommit && readRelease) begin
                    w_swap = 1'b1;
                end else if (writeCommit) begin
                    w_overrun = 1'b1;
                end else if (readRelease) begin
                    w_stateNext = S_EMPTY;
                end
            end
            default: w_stateNext = S_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_writeBank  <= 1'b0;
            r_writeCount <= '0;
            r_readLength <= '0;
            r_readData   <= '0;
            r_readValid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_overrun   <= w_overrun;
            r_readValid <= readEnable & (r_state == S_FULL);
            // Uses the pre-swap bank select, so a read in a swap cycle sees the old read bank.
            if (readEnable)
                r_readData <= r_mem[{~r_writeBank, readAddress}];
            r_writeCount <= writeCommit ? '0 : w_countNext;
            if (w_swap) begin
                r_writeBank  <= ~r_writeBank;
                r_readLength <= w_countNext;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (writeEnable)
            r_mem[{r_writeBank, writeAddress}] <= writeData;
    end

`ifdef PING_PONG_OVERRUN_COUNT_EN
    logic [15:0] r_overrunCount;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_overrunCount <= '0;
        else if (w_overrun && r_overrunCount != 16'hFFFF)
            r_overrunCount <= r_overrunCount + 16'd1;
    end
    assign overrunCount = r_overrunCount;
`else
    assign overrunCount = 16'd0;
`endif

    assign readData   = r_readData;
    assign readValid  = r_readValid;
    assign bankReady  = (r_state == S_FULL);
    assign readLength = r_readLength;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_ping_pong_buffer.sv
// Directed self-checking bench for ping_pong_buffer (default parameters).
module tb_ping_pong_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        writeEnable = 1'b0;
    logic [7:0]  writeAddress = '0;
    logic [9:0]  writeData = '0;
    logic        writeCommit = 1'b0;
    logic        readEnable = 1'b0;
    logic [7:0]  readAddress = '0;
    logic [9:0]  readData;
    logic        readValid;
    logic        bankReady;
    logic [8:0]  readLength;
    logic        readRelease = 1'b0;
    logic        overrun;
    logic [15:0] overrunCount;

    int total = 0;
    int bad   = 0;

`ifdef PING_PONG_OVERRUN_COUNT_EN
    localparam logic [15:0] EXP_OVR_CNT = 16'd1;
`else
    localparam logic [15:0] EXP_OVR_CNT = 16'd0;
`endif

    ping_pong_buffer #(.DATA_WIDTH(10), .ADDRESS_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
        .writeCommit(writeCommit),
        .readEnable(readEnable), .readAddress(readAddress),
        .readData(readData), .readValid(readValid),
        .bankReady(bankReady), .readLength(readLength),
        .readRelease(readRelease),
        .overrun(overrun), .overrunCount(overrunCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        writeEnable  = 1'b1;
        writeAddress = addr[7:0];
        writeData    = data[9:0];
        tick();
        writeEnable  = 1'b0;
    endtask

    task automatic rd(input int addr);
        readEnable  = 1'b1;
        readAddress = addr[7:0];
        tick();
        readEnable  = 1'b0;
    endtask

    task automatic pulse_commit(input logic rel);
        writeCommit = 1'b1;
        readRelease = rel;
        tick();
        writeCommit = 1'b0;
        readRelease = 1'b0;
    endtask

    task automatic pulse_release();
        readRelease = 1'b1;
        tick();
        readRelease = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_bankReady", 32'(bankReady), 0);
        chk("rst_readLength", 32'(readLength), 0);
        chk("rst_readValid", 32'(readValid), 0);
        chk("rst_overrunCount", 32'(overrunCount), 0);

        // Boundaries in EMPTY: release ignored, read gives no valid.
        pulse_release();
        chk("empty_release_ignored", 32'(bankReady), 0);
        rd(0);
        chk("empty_read_valid", 32'(readValid), 0);

        // Basic swap: frame A, data = addr+100.
        for (int i = 0; i < 10; i++) wr(i, i + 100);
        pulse_commit(1'b0);
        chk("swapA_bankReady", 32'(bankReady), 1);
        chk("swapA_readLength", 32'(readLength), 10);
        rd(3);
        chk("swapA_readData", 32'(readData), 103);
        chk("swapA_readValid", 32'(readValid), 1);

        // Ping-pong: frame B, data = addr+200.
        pulse_release();
        chk("release_bankReady", 32'(bankReady), 0);
        for (int i = 0; i < 4; i++) wr(i, i + 200);
        pulse_commit(1'b0);
        chk("swapB_readLength", 32'(readLength), 4);
        rd(2);
        chk("swapB_readData2", 32'(readData), 202);
        rd(3);
        chk("swapB_hidesA", 32'(readData), 203);

        // Overrun: commit while FULL without release.
        for (int i = 0; i < 5; i++) wr(i, i + 300);
        pulse_commit(1'b0);
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_readLength", 32'(readLength), 4);
        chk("ovr_bankReady", 32'(bankReady), 1);
        chk("ovr_count", 32'(overrunCount), 32'(EXP_OVR_CNT));
        tick();
        chk("ovr_pulse_end", 32'(overrun), 0);
        rd(2);
        chk("ovr_readbank_kept", 32'(readData), 202);

        // Simultaneous commit+release, with a write in the commit cycle.
        wr(0, 400);
        wr(1, 401);
        writeEnable  = 1'b1;
        writeAddress = 8'd2;
        writeData    = 10'd402;
        pulse_commit(1'b1);
        writeEnable  = 1'b0;
        chk("sim_bankReady", 32'(bankReady), 1);
        chk("sim_overrun", 32'(overrun), 0);
        chk("sim_readLength", 32'(readLength), 3);
        rd(2);
        chk("sim_readData", 32'(readData), 402);

        // Count saturation: 259 writes, addresses wrap.
        pulse_release();
        for (int i = 0; i < 259; i++) wr(i % 256, i);
        pulse_commit(1'b0);
        chk("sat_readLength", 32'(readLength), 256);
        rd(10);
        chk("sat_readData10", 32'(readData), 10);
        rd(1);
        chk("sat_readData1", 32'(readData), 257);

        // Asynchronous reset mid-frame.
        rd(1);
        wr(0, 55);
        writeEnable = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_bankReady", 32'(bankReady), 0);
        chk("arst_readLength", 32'(readLength), 0);
        chk("arst_readData", 32'(readData), 0);
        chk("arst_readValid", 32'(readValid), 0);
        chk("arst_overrunCount", 32'(overrunCount), 0);
        writeEnable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        // Partial frame lost: an empty commit yields length 0.
        pulse_commit(1'b0);
        chk("post_rst_bankReady", 32'(bankReady), 1);
        chk("post_rst_readLength", 32'(readLength), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
